// File: rtl/io_uart_tx.sv
// Memory-mapped console transmitter: CPU stores to ADDR_TX feed a small FIFO drained by an
// 8N1 serialiser; ADDR_STAT returns {overrun, empty, full, busy} one cycle after the load.
module io_uart_tx #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned DEPTH     = 4,
    parameter logic [9:0]  ADDR_TX   = 10'h001,
    parameter logic [9:0]  ADDR_STAT = 10'h003
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  mem_addr,
    input  logic        mem_wr,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        rd_hit,
    output logic        uart_tx,
    output logic        tx_busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] CYC_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_next;
    logic          full, empty;
    logic          push_req, push_ok, pop, drop, stat_rd;
    logic          bit_end, going_idle;
    logic          overrun;

    state_t        state;
    logic [CW-1:0] cyc;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    logic unused_bits;
    assign unused_bits = &{1'b0, wr_data[15:8]};

    always_comb begin
        full     = (count == FULL_CNT);
        empty    = (count == '0);
        push_req = mem_wr && (mem_addr == ADDR_TX);
        stat_rd  = !mem_wr && (mem_addr == ADDR_STAT);
        bit_end  = (cyc == CYC_LAST);
        // The FIFO is popped either from IDLE or at the last stop-bit cycle, giving gapless frames.
        pop        = !empty && ((state == IDLE) || ((state == STOP) && bit_end));
        going_idle = empty && ((state == IDLE) || ((state == STOP) && bit_end));
        push_ok    = push_req && (!full || pop);
        drop       = push_req && !push_ok;
        count_next = count;
        case ({push_ok, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
            rd_hit  <= 1'b0;
            rd_data <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            // A drop on the same edge as a status read keeps the flag set.
            if (drop)         overrun <= 1'b1;
            else if (stat_rd) overrun <= 1'b0;
            rd_hit  <= stat_rd;
            rd_data <= stat_rd ? {12'b0, overrun, empty, full, tx_busy} : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cyc     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            uart_tx <= 1'b1;
            tx_busy <= 1'b0;
        end else begin
            tx_busy <= (count_next != '0) || !going_idle;
            case (state)
                IDLE: begin
                    uart_tx <= 1'b1;
                    if (pop) begin
                        shreg   <= mem[rd_ptr];
                        cyc     <= '0;
                        uart_tx <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cyc     <= '0;
                        bit_idx <= '0;
                        uart_tx <= shreg[0];
                        state   <= DATA;
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cyc <= '0;
                        if (bit_idx == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shreg   <= {1'b0, shreg[7:1]};
                            uart_tx <= shreg[1];
                        end
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cyc <= '0;
                        if (pop) begin
                            shreg   <= mem[rd_ptr];
                            uart_tx <= 1'b0;
                            state   <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cyc <= cyc + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx: accepted bytes are queued as expected frames and a line
// monitor checks every serial cycle against them; status reads are checked inline.
module tb_io_uart_tx;

    localparam int unsigned CLK_DIV   = 4;
    localparam int unsigned DEPTH     = 4;
    localparam logic [9:0]  ADDR_TX   = 10'h001;
    localparam logic [9:0]  ADDR_STAT = 10'h003;
    localparam logic [9:0]  ADDR_IDLE = 10'h100;
    localparam int unsigned FRAME_T   = 10 * CLK_DIV * 10;

    logic        clk;
    logic        rst_n;
    logic [9:0]  mem_addr;
    logic        mem_wr;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        rd_hit;
    logic        uart_tx;
    logic        tx_busy;

    int   total = 0;
    int   bad = 0;
    int   frames_done = 0;
    bit   mon_en = 1'b0;
    time  t_edge;
    time  t0;
    int   fd0;
    int   lows;
    logic [7:0] exp_q [$];
    time  start_q [$];

    io_uart_tx #(
        .CLK_DIV(CLK_DIV),
        .DEPTH(DEPTH),
        .ADDR_TX(ADDR_TX),
        .ADDR_STAT(ADDR_STAT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mem_addr(mem_addr),
        .mem_wr(mem_wr),
        .wr_data(wr_data),
        .rd_data(rd_data),
        .rd_hit(rd_hit),
        .uart_tx(uart_tx),
        .tx_busy(tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [9:0] a, input logic [7:0] d, input bit accept);
        mem_addr = a;
        mem_wr   = 1'b1;
        wr_data  = {8'hC3, d};
        @(posedge clk);
        t_edge = $time;
        #1;
        mem_wr   = 1'b0;
        mem_addr = ADDR_IDLE;
        wr_data  = '0;
        if (a == ADDR_TX && accept) exp_q.push_back(d);
    endtask

    task automatic rd_stat(input logic [15:0] exp, input string tag);
        mem_addr = ADDR_STAT;
        mem_wr   = 1'b0;
        @(posedge clk);
        #1;
        mem_addr = ADDR_IDLE;
        chk({tag, "_hit"}, 32'(rd_hit), 1);
        chk(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic wait_frames(input int target, input int budget, input string tag);
        int n = 0;
        while (frames_done < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({tag, "_frames"}, 32'(frames_done >= target), 1);
    endtask

    // Line monitor: a low level at a falling clock edge marks cycle 0 of a start bit.
    initial begin
        logic [7:0] b;
        bit complete;
        int k;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && uart_tx === 1'b0) begin
                start_q.push_back($time);
                chk("frame_expected", 32'(exp_q.size() != 0), 1);
                b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
                complete = 1'b1;
                for (int c = 0; c < 10 * CLK_DIV; c++) begin
                    if (c > 0) @(negedge clk);
                    if (!mon_en) begin
                        complete = 1'b0;
                        break;
                    end
                    k = c / CLK_DIV;
                    chk($sformatf("frame_%0h_cyc%0d", b, c), 32'(uart_tx),
                        (k == 0) ? 0 : (k <= 8) ? 32'(b[k-1]) : 1);
                end
                if (complete) frames_done++;
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        mem_addr = ADDR_IDLE;
        mem_wr   = 1'b0;
        wr_data  = '0;
        #12;
        chk("rst_uart_tx", 32'(uart_tx), 1);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_rd_hit", 32'(rd_hit), 0);
        chk("rst_tx_busy", 32'(tx_busy), 0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        rd_stat(16'h0004, "stat_after_reset");

        // single byte, latency and busy timing
        start_q.delete();
        wr(ADDR_TX, 8'hA5, 1'b1);
        @(negedge clk);
        chk("t1_line_high_at_capture", 32'(uart_tx), 1);
        chk("t1_busy_after_push", 32'(tx_busy), 1);
        repeat (40) @(negedge clk);
        chk("t1_busy_in_last_stop", 32'(tx_busy), 1);
        @(posedge clk);
        #1;
        chk("t1_busy_fall", 32'(tx_busy), 0);
        chk("t1_line_idle", 32'(uart_tx), 1);
        chk("t1_frames", 32'(frames_done), 1);
        chk("t1_starts", 32'(start_q.size()), 1);
        if (start_q.size() > 0) chk("t1_start_latency", 32'(start_q[0] - t_edge), 15);

        // overfill, overrun flag and its clear-on-read
        start_q.delete();
        fd0 = frames_done;
        wr(ADDR_TX, 8'h11, 1'b1);
        wr(ADDR_TX, 8'h22, 1'b1);
        wr(ADDR_TX, 8'h33, 1'b1);
        wr(ADDR_TX, 8'h44, 1'b1);
        wr(ADDR_TX, 8'h55, 1'b1);
        wr(ADDR_TX, 8'h66, 1'b0);
        rd_stat(16'h000B, "t2_status_overrun");
        rd_stat(16'h0003, "t3_status_reread");
        wait_frames(fd0 + 5, 300, "t2");
        for (int i = 0; i + 1 < start_q.size(); i++)
            chk($sformatf("t2_gap_%0d", i), 32'(start_q[i+1] - start_q[i]), FRAME_T);
        rd_stat(16'h0004, "t2_status_drained");

        // two back-to-back frames
        start_q.delete();
        fd0 = frames_done;
        wr(ADDR_TX, 8'h00, 1'b1);
        t0 = t_edge;
        wr(ADDR_TX, 8'hFF, 1'b1);
        wait_frames(fd0 + 2, 120, "t4");
        chk("t4_starts", 32'(start_q.size()), 2);
        if (start_q.size() >= 2) begin
            chk("t4_start_latency", 32'(start_q[0] - t0), 15);
            chk("t4_gapless", 32'(start_q[1] - start_q[0]), FRAME_T);
        end
        rd_stat(16'h0004, "t4_status");

        // other addresses are ignored
        fd0 = frames_done;
        wr(10'h000, 8'h5A, 1'b1);
        chk("t5_store_no_hit", 32'(rd_hit), 0);
        mem_addr = 10'h002;
        @(posedge clk);
        #1;
        chk("t5_load_no_hit", 32'(rd_hit), 0);
        chk("t5_load_no_data", 32'(rd_data), 0);
        mem_addr = ADDR_STAT;
        mem_wr   = 1'b1;
        @(posedge clk);
        #1;
        mem_wr   = 1'b0;
        mem_addr = ADDR_IDLE;
        chk("t5_store_to_stat_no_hit", 32'(rd_hit), 0);
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        chk("t5_line_stays_high", 32'(lows), 0);
        chk("t5_not_busy", 32'(tx_busy), 0);
        chk("t5_no_frames", 32'(frames_done), 32'(fd0));
        @(posedge clk);
        #1;
        rd_stat(16'h0004, "t5_status");
        @(posedge clk);
        #1;
        chk("t5_hit_drops", 32'(rd_hit), 0);
        chk("t5_data_drops", 32'(rd_data), 0);

        // reset in the middle of data bit 3 with two bytes queued
        fd0 = frames_done;
        wr(ADDR_TX, 8'h42, 1'b1);
        wr(ADDR_TX, 8'h81, 1'b1);
        wr(ADDR_TX, 8'hC3, 1'b1);
        repeat (16) @(posedge clk);
        #2;
        chk("t6_pre_reset_bit3", 32'(uart_tx), 0);
        chk("t6_pre_reset_busy", 32'(tx_busy), 1);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("t6_async_line_high", 32'(uart_tx), 1);
        chk("t6_async_busy_low", 32'(tx_busy), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        rd_stat(16'h0004, "t6_status");
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        chk("t6_no_more_frames_line", 32'(lows), 0);
        chk("t6_no_more_frames", 32'(frames_done), 32'(fd0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
